nms_stage: RTL and testbench

NMS_STAGE -- requirements
Module: nms_stage

---
 rtl/nms_stage.sv | 172 +++++++++++++++++
 tb/tb_nms_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nms_stage.sv
// Non-maximum suppression stage between the Sobel FIFO and the hysteresis FIFO.
// A 2*WIDTH+3 shift register forms the 3x3 window; one pixel is produced per NMS/OUTPUT pair.
module nms_stage #(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] in_dout,
    input  logic       in_empty,
    output logic       in_rd_en,
    output logic [7:0] out_din,
    output logic       out_wr_en,
    input  logic       out_full,
    output logic       frame_done
);

    localparam int DEPTH = 2 * WIDTH + 3;
    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int PW    = $clog2(NPIX + 1);
    localparam int QW    = $clog2(WIDTH + 3);
    localparam int CW    = $clog2(WIDTH);
    localparam int RW    = $clog2(HEIGHT);

    localparam logic [PW-1:0] NPIX_C     = PW'(NPIX);
    localparam logic [QW-1:0] PRO_LAST_C = QW'(WIDTH + 1);
    localparam logic [CW-1:0] COL_LAST_C = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST_C = RW'(HEIGHT - 1);

    localparam logic [1:0] ST_PROLOGUE = 2'd0;
    localparam logic [1:0] ST_NMS      = 2'd1;
    localparam logic [1:0] ST_OUTPUT   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [9:0]    lb_q [DEPTH];
    logic [7:0]    result_q, result_d;
    logic [PW-1:0] pop_cnt_q, pop_cnt_d;
    logic [QW-1:0] pro_cnt_q, pro_cnt_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic       all_popped_s, pop_s, shift_s, last_col_s, last_row_s, border_s;
    logic [9:0] shift_word_s;
    logic [7:0] mag_c_s, mag_a_s, mag_b_s, result_s;

    assign all_popped_s = (pop_cnt_q == NPIX_C);
    assign pop_s        = reset && !in_empty && !all_popped_s &&
                          ((state_q == ST_PROLOGUE) || (state_q == ST_NMS));
    // Once the frame is fully popped, NMS keeps the window moving with zero words.
    assign shift_s      = pop_s || ((state_q == ST_NMS) && all_popped_s);
    assign shift_word_s = pop_s ? in_dout : 10'd0;

    assign last_col_s = (col_q == COL_LAST_C);
    assign last_row_s = (row_q == ROW_LAST_C);
    assign border_s   = (row_q == RW'(0)) || last_row_s || (col_q == CW'(0)) || last_col_s;

    assign in_rd_en   = pop_s;
    assign out_wr_en  = (state_q == ST_OUTPUT) && !out_full;
    assign out_din    = out_wr_en ? result_q : 8'd0;
    assign frame_done = out_wr_en && last_row_s && last_col_s;

    // Window taps: lb_q[0] is p9 (newest), lb_q[WIDTH+1] is p5, lb_q[2*WIDTH+2] is p1.
    always_comb begin
        mag_c_s = lb_q[WIDTH+1][7:0];
        case (lb_q[WIDTH+1][9:8])
            2'd0: begin mag_a_s = lb_q[WIDTH+2][7:0];   mag_b_s = lb_q[WIDTH][7:0]; end
            2'd1: begin mag_a_s = lb_q[2*WIDTH][7:0];   mag_b_s = lb_q[2][7:0];     end
            2'd2: begin mag_a_s = lb_q[2*WIDTH+1][7:0]; mag_b_s = lb_q[1][7:0];     end
            2'd3: begin mag_a_s = lb_q[2*WIDTH+2][7:0]; mag_b_s = lb_q[0][7:0];     end
            default: begin mag_a_s = 8'd0; mag_b_s = 8'd0; end
        endcase
        if (border_s) begin
            result_s = 8'd0;
        end else if ((mag_c_s >= mag_a_s) && (mag_c_s >= mag_b_s)) begin
            result_s = mag_c_s;
        end else begin
            result_s = 8'd0;
        end
    end

    // Next-state logic for the PROLOGUE/NMS/OUTPUT sequencer and its counters.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        pro_cnt_d = pro_cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        pop_cnt_d = pop_s ? pop_cnt_q + PW'(1) : pop_cnt_q;
        case (state_q)
            ST_PROLOGUE: begin
                if (pop_s) begin
                    pro_cnt_d = pro_cnt_q + QW'(1);
                    if (pro_cnt_q == PRO_LAST_C) begin
                        state_d = ST_NMS;
                    end else begin
                        state_d = ST_PROLOGUE;
                    end
                end else begin
                    state_d = ST_PROLOGUE;
                end
            end
            ST_NMS: begin
                if (shift_s) begin
                    result_d = result_s;
                    state_d  = ST_OUTPUT;
                end else begin
                    state_d  = ST_NMS;
                end
            end
            ST_OUTPUT: begin
                if (!out_full) begin
                    state_d = ST_NMS;
                    if (!last_col_s) begin
                        col_d = col_q + CW'(1);
                    end else if (!last_row_s) begin
                        col_d = CW'(0);
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d     = CW'(0);
                        row_d     = RW'(0);
                        pro_cnt_d = QW'(0);
                        pop_cnt_d = PW'(0);
                        state_d   = ST_PROLOGUE;
                    end
                end else begin
                    state_d = ST_OUTPUT;
                end
            end
            default: begin
                state_d = ST_PROLOGUE;
            end
        endcase
    end

    // Sequencer state, counters and registered result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_PROLOGUE;
            result_q  <= 8'd0;
            pop_cnt_q <= PW'(0);
            pro_cnt_q <= QW'(0);
            col_q     <= CW'(0);
            row_q     <= RW'(0);
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            pop_cnt_q <= pop_cnt_d;
            pro_cnt_q <= pro_cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
        end
    end

    // Line buffer shifts one entry per pop or zero-fill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                lb_q[i] <= 10'd0;
            end
        end else if (shift_s) begin
            lb_q[0] <= shift_word_s;
            for (int i = 1; i < DEPTH; i++) begin
                lb_q[i] <= lb_q[i-1];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                lb_q[i] <= lb_q[i];
            end
        end
    end

endmodule

// File: tb/tb_nms_stage.sv
// Directed bench for nms_stage at WIDTH=8, HEIGHT=6: per-scenario tasks with inline checks.
module tb_nms_stage;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] in_dout = 10'd0;
    logic       in_empty = 1'b1;
    logic       in_rd_en;
    logic [7:0] out_din;
    logic       out_wr_en;
    logic       out_full = 1'b0;
    logic       frame_done;

    int tests = 0;
    int fails = 0;

    logic [9:0] frame [N];
    logic [7:0] got [N];
    int n_out, fd_cnt, fd_at;

    nms_stage #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out_din   (out_din),
        .out_wr_en (out_wr_en),
        .out_full  (out_full),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] mag_at(input int r, input int c);
        return frame[r*W+c][7:0];
    endfunction

    // Independent 2D reference of the suppression rule.
    function automatic logic [7:0] ref_px(input int r, input int c);
        logic [7:0] m, a, b;
        if (r == 0 || r == H-1 || c == 0 || c == W-1) return 8'd0;
        m = mag_at(r, c);
        case (frame[r*W+c][9:8])
            2'd0:    begin a = mag_at(r, c-1);   b = mag_at(r, c+1);   end
            2'd1:    begin a = mag_at(r-1, c+1); b = mag_at(r+1, c-1); end
            2'd2:    begin a = mag_at(r-1, c);   b = mag_at(r+1, c);   end
            default: begin a = mag_at(r-1, c-1); b = mag_at(r+1, c+1); end
        endcase
        return (m >= a && m >= b) ? m : 8'd0;
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < N; i++) frame[i] = 10'd0;
    endtask

    task automatic random_frame();
        for (int i = 0; i < N; i++) frame[i] = {2'($urandom_range(3)), 8'($urandom_range(255))};
    endtask

    // Feeds the current frame and collects outputs; abort_at >= 0 stops after that many writes.
    task automatic run_frame(input int empty_pct, input int stall_at, input int abort_at);
        int idx = 0;
        int stall_left = 0;
        bit stalled = 1'b0;
        bit done = 1'b0;
        int cyc = 0;
        n_out = 0; fd_cnt = 0; fd_at = -1;
        while (!done && cyc < 3000) begin
            @(negedge clock);
            cyc++;
            if (n_out == stall_at && !stalled) begin
                stalled = 1'b1;
                stall_left = 5;
            end
            out_full = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            in_empty = (idx >= N) || (empty_pct > 0 && $urandom_range(99) < empty_pct);
            in_dout  = (idx < N) ? frame[idx] : 10'd0;
            #1;
            tests++;
            if (out_wr_en && out_full) begin
                fails++;
                $display("FAIL wr_while_full: out_wr_en=%0b out_full=%0b required no write", out_wr_en, out_full);
            end
            if (!out_wr_en && out_din !== 8'd0) begin
                fails++;
                $display("FAIL din_idle: out_din=%0d required 0 when out_wr_en=0", out_din);
            end
            if (in_rd_en && in_empty) begin
                fails++;
                $display("FAIL pop_empty: in_rd_en=1 while in_empty=1");
            end
            if (in_rd_en) idx++;
            if (out_wr_en) begin
                if (n_out < N) got[n_out] = out_din;
                if (frame_done) begin
                    fd_cnt++;
                    fd_at = n_out + 1;
                end
                n_out++;
            end
            if (frame_done || n_out >= N || (abort_at >= 0 && n_out >= abort_at)) done = 1'b1;
        end
        in_empty = 1'b1;
        out_full = 1'b0;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL timeout: outputs=%0d required %0d within cycle budget", n_out, N);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_empty = 1'b0;
        in_dout = 10'h3ff;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            tests++;
            if ({in_rd_en, out_wr_en, frame_done} !== 3'b000) begin
                fails++;
                $display("FAIL reset_outputs: rd/wr/done=%b required 000", {in_rd_en, out_wr_en, frame_done});
            end
        end
        in_empty = 1'b1;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_isolated_peak();
        logic [7:0] exp;
        clear_frame();
        frame[2*W+3] = {2'd0, 8'd100};
        run_frame(0, -1, -1);
        tests++;
        if (n_out !== N || fd_cnt !== 1 || fd_at !== N) begin
            fails++;
            $display("FAIL peak_frame: outputs=%0d done=%0d at=%0d required %0d/1/%0d", n_out, fd_cnt, fd_at, N, N);
        end
        for (int i = 0; i < N; i++) begin
            exp = (i == 19) ? 8'd100 : 8'd0;
            tests++;
            if (got[i] !== exp) begin
                fails++;
                $display("FAIL peak_px%0d: got %0d required %0d", i, got[i], exp);
            end
        end
    endtask

    task automatic test_direction();
        clear_frame();
        frame[2*W+3] = {2'd3, 8'd60};
        frame[1*W+2] = {2'd0, 8'd70};
        run_frame(0, -1, -1);
        tests++;
        if (got[19] !== 8'd0 || got[10] !== 8'd70) begin
            fails++;
            $display("FAIL dir135: px19=%0d px10=%0d required 0 and 70", got[19], got[10]);
        end
        frame[2*W+3] = {2'd1, 8'd60};
        run_frame(0, -1, -1);
        tests++;
        if (got[19] !== 8'd60 || got[10] !== 8'd70) begin
            fails++;
            $display("FAIL dir45: px19=%0d px10=%0d required 60 and 70", got[19], got[10]);
        end
    endtask

    task automatic test_border();
        int nz = 0;
        clear_frame();
        frame[0*W+3] = {2'd0, 8'd200};
        frame[4*W+7] = {2'd0, 8'd200};
        run_frame(0, -1, -1);
        for (int i = 0; i < N; i++) if (got[i] !== 8'd0) nz++;
        tests++;
        if (nz != 0 || n_out !== N) begin
            fails++;
            $display("FAIL border: nonzero=%0d outputs=%0d required 0 and %0d", nz, n_out, N);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        random_frame();
        run_frame(30, 20, -1);
        for (int i = 0; i < N; i++) if (got[i] !== ref_px(i / W, i % W)) bad++;
        tests++;
        if (bad != 0 || n_out !== N || fd_cnt !== 1) begin
            fails++;
            $display("FAIL stall_stream: bad=%0d outputs=%0d done=%0d required 0/%0d/1", bad, n_out, fd_cnt, N);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            int bad = 0;
            random_frame();
            run_frame(0, -1, -1);
            for (int i = 0; i < N; i++) if (got[i] !== ref_px(i / W, i % W)) bad++;
            tests++;
            if (bad != 0 || fd_at !== N) begin
                fails++;
                $display("FAIL b2b_frame%0d: bad=%0d done_at=%0d required 0 and %0d", f, bad, fd_at, N);
            end
        end
    endtask

    task automatic test_midframe_reset();
        int bad = 0;
        random_frame();
        run_frame(0, -1, 20);
        @(negedge clock);
        reset = 1'b0;
        #1;
        tests++;
        if ({in_rd_en, out_wr_en, out_din} !== 10'd0) begin
            fails++;
            $display("FAIL midreset_outputs: rd=%0b wr=%0b din=%0d required all 0", in_rd_en, out_wr_en, out_din);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        random_frame();
        run_frame(0, -1, -1);
        for (int i = 0; i < N; i++) if (got[i] !== ref_px(i / W, i % W)) bad++;
        tests++;
        if (bad != 0 || n_out !== N || fd_cnt !== 1) begin
            fails++;
            $display("FAIL midreset_frame: bad=%0d outputs=%0d done=%0d required 0/%0d/1", bad, n_out, fd_cnt, N);
        end
    endtask

    initial begin
        test_reset();
        test_isolated_peak();
        test_direction();
        test_border();
        test_backpressure();
        test_back_to_back();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
